jtframe_slot_rq: RTL and testbench



---
 rtl/jtframe_slot_rq.sv | 237 +++++++++++++++++++++++
 tb/tb_jtframe_slot_rq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_slot_rq.sv
// ---------------------------------------------------------------------------
// jtframe_slot_rq
// Single-client SDRAM request generator for the JTFRAME slot arbiters.
// Converts a client address plus chip-select into a word-aligned SDRAM
// request, handshakes with the arbiter (req / we / din_ok), and returns the
// selected sub-word of the SDRAM data together with a data_ok flag.
//
// Modes (parameter CACHE):
//   1 = ROM mode: read-only, two-entry 32-bit cache, clr invalidates it.
//   0 = RAM mode: uncached, read/write selected by wrin.
//
// Parameters:
//   SDRAMW  SDRAM word (16-bit) address width
//   AW      client address width
//   DW      client data width (ROM: 8/16/32, RAM: 8/16)
//   CACHE   mode select, see above
//
// Ports:
//   rst         synchronous active-high reset
//   clk         clock
//   addr        client address, in DW-sized units
//   addr_ok     client chip-select / request valid
//   offset      region base added to the computed word address
//   clr         ROM mode cache invalidate (ignored in RAM mode)
//   wrin        RAM mode write (1) / read (0) (ignored in ROM mode)
//   req_rnw     1 = read, 0 = write, latched with the request
//   sdram_addr  registered SDRAM word address of the pending request
//   din         SDRAM read data, bits 15:0 are the lower word
//   din_ok      SDRAM data/completion strobe
//   we          arbiter grant for this slot
//   req         pending request to the arbiter
//   data_ok     dout is valid for the current addr
//   dout        client data
//
// Optional simulation checker: define JTFRAME_SLOT_CHECK_EN to flag SDRAM
// data that arrives for this slot without a pending request.
// ---------------------------------------------------------------------------
module jtframe_slot_rq #(
  parameter int SDRAMW = 22,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int CACHE  = 1
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              addr_ok,
  input  logic [SDRAMW-1:0] offset,
  input  logic              clr,
  input  logic              wrin,
  output logic              req_rnw,
  output logic [SDRAMW-1:0] sdram_addr,
  input  logic [31:0]       din,
  input  logic              din_ok,
  input  logic              we,
  output logic              req,
  output logic              data_ok,
  output logic [DW-1:0]     dout
);

  logic [AW:0]       word_lsb;
  logic [SDRAMW-1:0] word_addr;
  logic              fill;
  logic              need;
  logic              issue;
  logic [AW-1:0]     addr_l;
  logic              wrin_l;

  // Scale the client address into SDRAM 16-bit word units. ROM mode always
  // fetches a full 32-bit pair, so the word address stays even; RAM mode
  // addresses single 16-bit words. The sum wraps at SDRAMW bits.
  always_comb begin
    word_lsb = '0;
    if (CACHE != 0) begin
      if (DW == 8)
        word_lsb = {2'b00, addr[AW-1:2], 1'b0};
      else if (DW == 16)
        word_lsb = {1'b0, addr[AW-1:1], 1'b0};
      else
        word_lsb = {addr, 1'b0};
    end else begin
      if (DW == 8)
        word_lsb = {2'b00, addr[AW-1:1]};
      else
        word_lsb = {1'b0, addr};
    end
    word_addr = offset + SDRAMW'(word_lsb);
  end

  assign fill  = we && din_ok;
  assign issue = addr_ok && !req && need;

  // Request register. A completion strobe for this slot always drops req,
  // and takes priority over a new issue so the arbiter never sees a stale
  // request for one extra cycle. While req is high the address and rnw
  // stay frozen, so a pending request is never aborted by addr changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      req        <= 1'b0;
      req_rnw    <= 1'b1;
      sdram_addr <= '0;
      addr_l     <= '0;
      wrin_l     <= 1'b0;
    end else if (fill) begin
      req <= 1'b0;
    end else if (issue) begin
      req        <= 1'b1;
      sdram_addr <= word_addr;
      req_rnw    <= (CACHE != 0) ? 1'b1 : ~wrin;
      addr_l     <= addr;
      wrin_l     <= wrin;
    end
  end

  generate
    if (CACHE != 0) begin : g_rom
      logic              e0_v, e1_v;
      logic [SDRAMW-1:0] e0_tag, e1_tag;
      logic [31:0]       e0_data, e1_data;
      logic              hit0, hit1, hit;
      logic [31:0]       sel;
      logic              unused_rom;

      // Tag compare against both entries. When nothing hits, entry0 is
      // still routed to dout; its value is meaningless without data_ok.
      always_comb begin
        hit0 = addr_ok && e0_v && (e0_tag == word_addr);
        hit1 = addr_ok && e1_v && (e1_tag == word_addr);
        hit  = hit0 || hit1;
        sel  = (hit1 && !hit0) ? e1_data : e0_data;
      end

      assign data_ok = hit;
      assign need    = !hit;

      // Two-entry FIFO cache: each fill pushes the new line into entry0
      // and moves the old entry0 to entry1. clr wipes both valid bits and
      // wins over a fill landing in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          e0_v    <= 1'b0;
          e1_v    <= 1'b0;
          e0_tag  <= '0;
          e1_tag  <= '0;
          e0_data <= '0;
          e1_data <= '0;
        end else begin
          if (fill) begin
            e1_tag  <= e0_tag;
            e1_data <= e0_data;
            e0_tag  <= sdram_addr;
            e0_data <= din;
          end
          if (clr) begin
            e0_v <= 1'b0;
            e1_v <= 1'b0;
          end else if (fill) begin
            e1_v <= e0_v;
            e0_v <= 1'b1;
          end
        end
      end

      // Little-endian sub-word select out of the 32-bit line.
      if (DW == 8) begin : g_dw8
        assign dout = sel[{addr[1:0], 3'b000} +: 8];
      end else if (DW == 16) begin : g_dw16
        assign dout = addr[0] ? sel[31:16] : sel[15:0];
      end else begin : g_dw32
        assign dout = sel;
      end

      assign unused_rom = ^{wrin, wrin_l, addr_l};

`ifdef JTFRAME_SLOT_CHECK_EN
      // Simulation-only sanity check: data_ok must only follow a real hit.
      always @(posedge clk) begin
        if (!rst && data_ok && !hit) begin
          $display("ERROR: data_ok asserted without a cache hit (%0t)", $time);
          $finish;
        end
      end
`endif

    end else begin : g_ram
      logic          done;
      logic          match;
      logic [DW-1:0] sub;
      logic          unused_ram;

      assign match   = (addr_l == addr) && (wrin_l == wrin);
      assign data_ok = done && addr_ok && match;
      assign need    = !data_ok;

      if (DW == 8) begin : g_dw8
        assign sub = addr_l[0] ? din[15:8] : din[7:0];
      end else begin : g_dw16
        assign sub = din[15:0];
      end

      // done remembers that the latched access has completed. Any change
      // of address, direction or chip-select invalidates it first, so a
      // completion that arrives after the client moved on is not reported
      // and a fresh request is issued for the new access. Read data is
      // captured on completion; writes leave dout untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          done <= 1'b0;
          dout <= '0;
        end else begin
          if (!addr_ok || !match)
            done <= 1'b0;
          else if (fill)
            done <= 1'b1;
          if (fill && !wrin_l)
            dout <= sub;
        end
      end

      assign unused_ram = ^{clr, din[31:16]};
    end
  endgenerate

`ifdef JTFRAME_SLOT_CHECK_EN
  // Simulation-only protocol check: a granted completion strobe must
  // correspond to a request this slot actually raised.
  always @(posedge clk) begin
    if (!rst && din_ok && we && !req) begin
      $display("ERROR: SDRAM data received but it had not been requested (%0t)", $time);
      $finish;
    end
  end
`else
  // No checker logic in normal builds.
`endif

endmodule

// File: tb/tb_jtframe_slot_rq.sv
// ---------------------------------------------------------------------------
// tb_jtframe_slot_rq
// Directed self-checking bench for jtframe_slot_rq. Two instances share the
// clock, reset and SDRAM data bus: one in ROM mode (DW=8, offset 0x100) and
// one in RAM mode (DW=16, offset 0x2000). Each has its own grant signal so
// completions are delivered to one slot at a time.
// ---------------------------------------------------------------------------
module tb_jtframe_slot_rq;

  localparam int SDRAMW = 22;
  localparam int AW     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       din;
  logic              din_ok;

  logic [AW-1:0]     rom_addr;
  logic              rom_addr_ok;
  logic              rom_clr;
  logic              rom_we;
  logic              rom_req;
  logic              rom_req_rnw;
  logic [SDRAMW-1:0] rom_sdram_addr;
  logic              rom_data_ok;
  logic [7:0]        rom_dout;

  logic [AW-1:0]     ram_addr;
  logic              ram_addr_ok;
  logic              ram_wrin;
  logic              ram_we;
  logic              ram_req;
  logic              ram_req_rnw;
  logic [SDRAMW-1:0] ram_sdram_addr;
  logic              ram_data_ok;
  logic [15:0]       ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_slot_rq #(.SDRAMW(SDRAMW), .AW(AW), .DW(8), .CACHE(1)) u_rom (
    .rst        (rst),
    .clk        (clk),
    .addr       (rom_addr),
    .addr_ok    (rom_addr_ok),
    .offset     (22'h000100),
    .clr        (rom_clr),
    .wrin       (1'b0),
    .req_rnw    (rom_req_rnw),
    .sdram_addr (rom_sdram_addr),
    .din        (din),
    .din_ok     (din_ok),
    .we         (rom_we),
    .req        (rom_req),
    .data_ok    (rom_data_ok),
    .dout       (rom_dout)
  );

  jtframe_slot_rq #(.SDRAMW(SDRAMW), .AW(AW), .DW(16), .CACHE(0)) u_ram (
    .rst        (rst),
    .clk        (clk),
    .addr       (ram_addr),
    .addr_ok    (ram_addr_ok),
    .offset     (22'h002000),
    .clr        (1'b0),
    .wrin       (ram_wrin),
    .req_rnw    (ram_req_rnw),
    .sdram_addr (ram_sdram_addr),
    .din        (din),
    .din_ok     (din_ok),
    .we         (ram_we),
    .req        (ram_req),
    .data_ok    (ram_data_ok),
    .dout       (ram_dout)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Deliver one granted completion to the ROM slot.
  task automatic rom_grant(input logic [31:0] data);
    din    = data;
    din_ok = 1'b1;
    rom_we = 1'b1;
    tick();
    din_ok = 1'b0;
    rom_we = 1'b0;
    #1;
  endtask

  // Deliver one granted completion to the RAM slot.
  task automatic ram_grant(input logic [31:0] data);
    din    = data;
    din_ok = 1'b1;
    ram_we = 1'b1;
    tick();
    din_ok = 1'b0;
    ram_we = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_req: got %0b expected 0", rom_req); end
    checks++; if (rom_req_rnw !== 1'b1) begin errors++; $display("[TB] FAIL reset_rom_rnw: got %0b expected 1", rom_req_rnw); end
    checks++; if (rom_sdram_addr !== 22'h0) begin errors++; $display("[TB] FAIL reset_rom_addr: got %h expected 0", rom_sdram_addr); end
    checks++; if (rom_dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_rom_dout: got %h expected 00", rom_dout); end
    checks++; if (rom_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_data_ok: got %0b expected 0", rom_data_ok); end
    checks++; if (ram_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_req: got %0b expected 0", ram_req); end
    checks++; if (ram_req_rnw !== 1'b1) begin errors++; $display("[TB] FAIL reset_ram_rnw: got %0b expected 1", ram_req_rnw); end
    checks++; if (ram_dout !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ram_dout: got %h expected 0000", ram_dout); end
    checks++; if (ram_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_data_ok: got %0b expected 0", ram_data_ok); end
  endtask

  task automatic test_rom_miss_fill();
    rom_addr    = 8'h05;
    rom_addr_ok = 1'b1;
    #1;
    checks++; if (rom_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rom_miss_data_ok: got %0b expected 0", rom_data_ok); end
    tick();
    checks++; if (rom_req !== 1'b1) begin errors++; $display("[TB] FAIL rom_issue_req: got %0b expected 1", rom_req); end
    checks++; if (rom_sdram_addr !== 22'h000102) begin errors++; $display("[TB] FAIL rom_issue_addr: got %h expected 000102", rom_sdram_addr); end
    checks++; if (rom_req_rnw !== 1'b1) begin errors++; $display("[TB] FAIL rom_issue_rnw: got %0b expected 1", rom_req_rnw); end
    rom_grant(32'h44332211);
    checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL rom_fill_req_low: got %0b expected 0", rom_req); end
    checks++; if (rom_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rom_fill_data_ok: got %0b expected 1", rom_data_ok); end
    checks++; if (rom_dout !== 8'h22) begin errors++; $display("[TB] FAIL rom_fill_dout: got %h expected 22", rom_dout); end
    tick();
    checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL rom_fill_no_rereq: got %0b expected 0", rom_req); end
  endtask

  task automatic test_rom_hit_evict();
    rom_addr = 8'h06;
    #1;
    checks++; if (rom_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rom_hit_data_ok: got %0b expected 1", rom_data_ok); end
    checks++; if (rom_dout !== 8'h33) begin errors++; $display("[TB] FAIL rom_hit_dout: got %h expected 33", rom_dout); end
    tick();
    checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL rom_hit_no_req: got %0b expected 0", rom_req); end
    rom_addr = 8'h09;
    tick();
    checks++; if (rom_sdram_addr !== 22'h000104 || rom_req !== 1'b1) begin errors++; $display("[TB] FAIL rom_line2_issue: got req=%0b addr=%h expected req=1 addr=000104", rom_req, rom_sdram_addr); end
    rom_grant(32'h88776655);
    checks++; if (rom_dout !== 8'h66 || rom_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rom_line2_dout: got ok=%0b dout=%h expected ok=1 dout=66", rom_data_ok, rom_dout); end
    rom_addr = 8'h05;
    #1;
    checks++; if (rom_dout !== 8'h22 || rom_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rom_entry1_hit: got ok=%0b dout=%h expected ok=1 dout=22", rom_data_ok, rom_dout); end
    rom_addr = 8'h0D;
    tick();
    checks++; if (rom_sdram_addr !== 22'h000106 || rom_req !== 1'b1) begin errors++; $display("[TB] FAIL rom_line3_issue: got req=%0b addr=%h expected req=1 addr=000106", rom_req, rom_sdram_addr); end
    rom_grant(32'hCCBBAA99);
    checks++; if (rom_dout !== 8'hAA || rom_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rom_line3_dout: got ok=%0b dout=%h expected ok=1 dout=aa", rom_data_ok, rom_dout); end
    rom_addr = 8'h05;
    #1;
    checks++; if (rom_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rom_evicted_miss: got %0b expected 0", rom_data_ok); end
    tick();
    checks++; if (rom_sdram_addr !== 22'h000102 || rom_req !== 1'b1) begin errors++; $display("[TB] FAIL rom_evicted_reissue: got req=%0b addr=%h expected req=1 addr=000102", rom_req, rom_sdram_addr); end
    rom_grant(32'h44332211);
    checks++; if (rom_dout !== 8'h22 || rom_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rom_refill_dout: got ok=%0b dout=%h expected ok=1 dout=22", rom_data_ok, rom_dout); end
  endtask

  task automatic test_rom_clr();
    rom_clr = 1'b1;
    tick();
    rom_clr = 1'b0;
    #1;
    checks++; if (rom_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rom_clr_data_ok: got %0b expected 0", rom_data_ok); end
    tick();
    checks++; if (rom_sdram_addr !== 22'h000102 || rom_req !== 1'b1) begin errors++; $display("[TB] FAIL rom_clr_reissue: got req=%0b addr=%h expected req=1 addr=000102", rom_req, rom_sdram_addr); end
    rom_clr = 1'b1;
    rom_grant(32'h44332211);
    rom_clr = 1'b0;
    #1;
    checks++; if (rom_data_ok !== 1'b0 || rom_req !== 1'b0) begin errors++; $display("[TB] FAIL rom_clr_fill_e0: got ok=%0b req=%0b expected ok=0 req=0", rom_data_ok, rom_req); end
    rom_addr = 8'h0D;
    #1;
    checks++; if (rom_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rom_clr_fill_e1: got %0b expected 0", rom_data_ok); end
    rom_addr_ok = 1'b0;
    tick();
  endtask

  task automatic test_rom_ignore_and_reset();
    rom_addr    = 8'h05;
    rom_addr_ok = 1'b1;
    tick();
    checks++; if (rom_req !== 1'b1) begin errors++; $display("[TB] FAIL rom_req_again: got %0b expected 1", rom_req); end
    din    = 32'hDEADBEEF;
    din_ok = 1'b1;
    tick();
    din_ok = 1'b0;
    #1;
    checks++; if (rom_req !== 1'b1 || rom_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rom_we0_ignored: got req=%0b ok=%0b expected req=1 ok=0", rom_req, rom_data_ok); end
    rom_grant(32'h44332211);
    checks++; if (rom_dout !== 8'h22 || rom_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rom_we1_fill: got ok=%0b dout=%h expected ok=1 dout=22", rom_data_ok, rom_dout); end
    rom_addr = 8'h09;
    tick();
    checks++; if (rom_req !== 1'b1) begin errors++; $display("[TB] FAIL rom_pre_reset_req: got %0b expected 1", rom_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rom_req !== 1'b0 || rom_sdram_addr !== 22'h0) begin errors++; $display("[TB] FAIL rom_reset_mid_req: got req=%0b addr=%h expected req=0 addr=0", rom_req, rom_sdram_addr); end
    rom_addr = 8'h05;
    #1;
    checks++; if (rom_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rom_reset_cache: got %0b expected 0", rom_data_ok); end
    rom_addr_ok = 1'b0;
    tick();
  endtask

  task automatic test_ram_write_read();
    ram_addr    = 8'h10;
    ram_wrin    = 1'b1;
    ram_addr_ok = 1'b1;
    tick();
    checks++; if (ram_req !== 1'b1 || ram_req_rnw !== 1'b0) begin errors++; $display("[TB] FAIL ram_wr_issue: got req=%0b rnw=%0b expected req=1 rnw=0", ram_req, ram_req_rnw); end
    checks++; if (ram_sdram_addr !== 22'h002010) begin errors++; $display("[TB] FAIL ram_wr_addr: got %h expected 002010", ram_sdram_addr); end
    ram_grant(32'h0000ABCD);
    checks++; if (ram_req !== 1'b0 || ram_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL ram_wr_done: got req=%0b ok=%0b expected req=0 ok=1", ram_req, ram_data_ok); end
    tick();
    checks++; if (ram_req !== 1'b0 || ram_data_ok !== 1'b1 || ram_dout !== 16'h0000) begin errors++; $display("[TB] FAIL ram_wr_hold: got req=%0b ok=%0b dout=%h expected req=0 ok=1 dout=0000", ram_req, ram_data_ok, ram_dout); end
    ram_wrin = 1'b0;
    #1;
    checks++; if (ram_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL ram_rd_mismatch: got %0b expected 0", ram_data_ok); end
    tick();
    checks++; if (ram_req !== 1'b1 || ram_req_rnw !== 1'b1 || ram_sdram_addr !== 22'h002010) begin errors++; $display("[TB] FAIL ram_rd_issue: got req=%0b rnw=%0b addr=%h expected req=1 rnw=1 addr=002010", ram_req, ram_req_rnw, ram_sdram_addr); end
    ram_grant(32'h1234BEEF);
    checks++; if (ram_data_ok !== 1'b1 || ram_dout !== 16'hBEEF) begin errors++; $display("[TB] FAIL ram_rd_data: got ok=%0b dout=%h expected ok=1 dout=beef", ram_data_ok, ram_dout); end
  endtask

  task automatic test_ram_addr_change();
    ram_addr = 8'h11;
    tick();
    checks++; if (ram_req !== 1'b1 || ram_sdram_addr !== 22'h002011) begin errors++; $display("[TB] FAIL ram_chg_issue: got req=%0b addr=%h expected req=1 addr=002011", ram_req, ram_sdram_addr); end
    ram_addr = 8'h22;
    tick();
    checks++; if (ram_req !== 1'b1 || ram_sdram_addr !== 22'h002011) begin errors++; $display("[TB] FAIL ram_chg_hold: got req=%0b addr=%h expected req=1 addr=002011", ram_req, ram_sdram_addr); end
    ram_grant(32'h00005555);
    checks++; if (ram_req !== 1'b0 || ram_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL ram_chg_first_done: got req=%0b ok=%0b expected req=0 ok=0", ram_req, ram_data_ok); end
    tick();
    checks++; if (ram_req !== 1'b1 || ram_sdram_addr !== 22'h002022) begin errors++; $display("[TB] FAIL ram_chg_second_issue: got req=%0b addr=%h expected req=1 addr=002022", ram_req, ram_sdram_addr); end
    ram_grant(32'h00007777);
    checks++; if (ram_data_ok !== 1'b1 || ram_dout !== 16'h7777 || ram_req !== 1'b0) begin errors++; $display("[TB] FAIL ram_chg_second_data: got ok=%0b dout=%h req=%0b expected ok=1 dout=7777 req=0", ram_data_ok, ram_dout, ram_req); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    din         = '0;
    din_ok      = 1'b0;
    rom_addr    = '0;
    rom_addr_ok = 1'b0;
    rom_clr     = 1'b0;
    rom_we      = 1'b0;
    ram_addr    = '0;
    ram_addr_ok = 1'b0;
    ram_wrin    = 1'b0;
    ram_we      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    $display("[TB] starting directed tests");
    test_reset();
    test_rom_miss_fill();
    test_rom_hit_evict();
    test_rom_clr();
    test_rom_ignore_and_reset();
    test_ram_write_read();
    test_ram_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
